// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer. It holds the decoder PC-source
// encoding, the FSM state encodings, the stage-control bundle with its reset and
// run values, and the register-match helper used by hazard detection.
package stage_ctrl_pkg;

  // Decoder pc_src_ctrl value meaning "fall through to PC+4".
  localparam logic [2:0] PC_NEXT = 3'd0;

  typedef enum logic [1:0] {
    StReset   = 2'd0,
    StRun     = 2'd1,
    StMemWait = 2'd2
  } ctrl_state_e;

  // Clear/load pair for every pipeline stage register.
  typedef struct packed {
    logic if_rst;
    logic id_rst;
    logic exe_rst;
    logic mem_rst;
    logic wb_rst;
    logic if_en;
    logic id_en;
    logic exe_en;
    logic mem_en;
    logic wb_en;
  } stage_ctl_t;

  // All stages held in clear, nothing loads.
  localparam stage_ctl_t StageCtlReset = '{
    if_rst: 1'b1, id_rst: 1'b1, exe_rst: 1'b1, mem_rst: 1'b1, wb_rst: 1'b1,
    if_en:  1'b0, id_en:  1'b0, exe_en:  1'b0, mem_en:  1'b0, wb_en:  1'b0
  };

  // Free-running pipeline: every stage loads, nothing clears.
  localparam stage_ctl_t StageCtlRun = '{
    if_rst: 1'b0, id_rst: 1'b0, exe_rst: 1'b0, mem_rst: 1'b0, wb_rst: 1'b0,
    if_en:  1'b1, id_en:  1'b1, exe_en:  1'b1, mem_en:  1'b1, wb_en:  1'b1
  };

  // A source register read in ID matches a pending write in EXE or MEM.
  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic raw_match(input logic       used,
                                     input logic [4:0] src,
                                     input logic       wen_exe,
                                     input logic [4:0] dst_exe,
                                     input logic       wen_mem,
                                     input logic [4:0] dst_mem);
    return used && (src != 5'd0) &&
           ((wen_exe && (src == dst_exe)) || (wen_mem && (src == dst_mem)));
  endfunction

endpackage

// File: rtl/stage_ctrl_hazard_detect.sv
// Combinational hazard detection for the pipeline sequencer.
// Inputs : ID instruction info (valid, PC source, rs/rt usage and addresses),
//          EXE/MEM branch flags and destination writes, MEM data-memory handshake.
// Outputs: raw_o (RAW interlock), br_mem_o (branch in MEM), br_id_exe_o (branch
//          in ID or EXE), mem_wait_o (MEM access outstanding this cycle).
module hazard_detect
  import stage_ctrl_pkg::*;
(
  input  logic       id_valid_i,
  input  logic [2:0] pc_src_ctrl_i,
  input  logic       rs_used_id_i,
  input  logic       rt_used_id_i,
  input  logic [4:0] addr_rs_id_i,
  input  logic [4:0] addr_rt_id_i,
  input  logic       is_branch_exe_i,
  input  logic       is_branch_mem_i,
  input  logic [4:0] regw_addr_exe_i,
  input  logic [4:0] regw_addr_mem_i,
  input  logic       wb_wen_exe_i,
  input  logic       wb_wen_mem_i,
  input  logic       mem_ren_i,
  input  logic       mem_wen_i,
  input  logic       mem_ack_i,
  output logic       raw_o,
  output logic       br_mem_o,
  output logic       br_id_exe_o,
  output logic       mem_wait_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = raw_match(rs_used_id_i, addr_rs_id_i, wb_wen_exe_i, regw_addr_exe_i,
                            wb_wen_mem_i, regw_addr_mem_i);
  assign rt_hit = raw_match(rt_used_id_i, addr_rt_id_i, wb_wen_exe_i, regw_addr_exe_i,
                            wb_wen_mem_i, regw_addr_mem_i);

  // WB is not checked: the register file writes in the first half cycle.
  assign raw_o       = id_valid_i && (rs_hit || rt_hit);
  assign br_mem_o    = is_branch_mem_i;
  assign br_id_exe_o = (id_valid_i && (pc_src_ctrl_i != PC_NEXT)) || is_branch_exe_i;
  assign mem_wait_o  = (mem_ren_i || mem_wen_i) && !mem_ack_i;

endmodule

// File: rtl/stage_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS CPU.
// Drives every stage's clear/load pair from hazard feedback (RAW interlock,
// branch flush, data-memory wait), runs the post-reset release sequence and
// keeps stall / flush / memory-wait performance counters.
// Ports: clk, rst (sync, active-high); ID/EXE/MEM hazard inputs; mem handshake;
//        *_rst / *_en per stage; sticky mem_err; stall_cnt, flush_cnt, memwait_cnt.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       pc_src_ctrl,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic [4:0]       addr_rs_id,
  input  logic [4:0]       addr_rt_id,
  input  logic             is_branch_exe,
  input  logic             is_branch_mem,
  input  logic [4:0]       regw_addr_exe,
  input  logic [4:0]       regw_addr_mem,
  input  logic             wb_wen_exe,
  input  logic             wb_wen_mem,
  input  logic             mem_ren,
  input  logic             mem_wen,
  input  logic             mem_ack,
  output logic             if_rst,
  output logic             id_rst,
  output logic             exe_rst,
  output logic             mem_rst,
  output logic             wb_rst,
  output logic             if_en,
  output logic             id_en,
  output logic             exe_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int unsigned RcW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned WcW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [RcW-1:0] RstLoad = RcW'(RST_CYCLES - 1);
  localparam logic [WcW-1:0] WaitMax = WcW'(MEM_TIMEOUT);

  logic raw, br_mem, br_id_exe, mem_wait;

  hazard_detect u_hazard_detect (
    .id_valid_i      (id_valid),
    .pc_src_ctrl_i   (pc_src_ctrl),
    .rs_used_id_i    (rs_used_id),
    .rt_used_id_i    (rt_used_id),
    .addr_rs_id_i    (addr_rs_id),
    .addr_rt_id_i    (addr_rt_id),
    .is_branch_exe_i (is_branch_exe),
    .is_branch_mem_i (is_branch_mem),
    .regw_addr_exe_i (regw_addr_exe),
    .regw_addr_mem_i (regw_addr_mem),
    .wb_wen_exe_i    (wb_wen_exe),
    .wb_wen_mem_i    (wb_wen_mem),
    .mem_ren_i       (mem_ren),
    .mem_wen_i       (mem_wen),
    .mem_ack_i       (mem_ack),
    .raw_o           (raw),
    .br_mem_o        (br_mem),
    .br_id_exe_o     (br_id_exe),
    .mem_wait_o      (mem_wait)
  );

  ctrl_state_e      state_q, state_d;
  logic [RcW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [WcW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  stage_ctl_t ctl;
  logic       wait_hit, raw_hit, flush_hit;

  // Output priority mux: memory wait > RAW > branch in MEM > branch in ID/EXE.
  // RAW outranks the ID-branch flush so a stalled branch is never discarded.
  always_comb begin
    ctl       = StageCtlRun;
    wait_hit  = 1'b0;
    raw_hit   = 1'b0;
    flush_hit = 1'b0;
    if (rst || (state_q == StReset)) begin
      ctl = StageCtlReset;
    end else begin
      // The ack cycle of a wait evaluates like a normal run cycle.
      wait_hit = ((state_q == StRun) && mem_wait) || ((state_q == StMemWait) && !mem_ack);
      if (wait_hit) begin
        ctl.if_en  = 1'b0;
        ctl.id_en  = 1'b0;
        ctl.exe_en = 1'b0;
        ctl.mem_en = 1'b0;
        ctl.wb_en  = 1'b0;
        ctl.wb_rst = 1'b1;
      end else if (raw) begin
        raw_hit     = 1'b1;
        ctl.if_en   = 1'b0;
        ctl.id_en   = 1'b0;
        ctl.exe_rst = 1'b1;
      end else if (br_mem) begin
        // IF keeps loading so the PC picks up the resolved target.
        ctl.id_rst = 1'b1;
      end else if (br_id_exe) begin
        ctl.if_en  = 1'b0;
        ctl.id_rst = 1'b1;
      end
      flush_hit = ctl.id_rst;
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    stall_cnt_d   = stall_cnt_q + {{(CNT_W - 1){1'b0}}, raw_hit};
    flush_cnt_d   = flush_cnt_q + {{(CNT_W - 1){1'b0}}, flush_hit};
    memwait_cnt_d = memwait_cnt_q + {{(CNT_W - 1){1'b0}}, wait_hit};
    unique case (state_q)
      StReset: begin
        if (rst_cnt_q == '0) state_d = StRun;
        else                 rst_cnt_d = rst_cnt_q - 1'b1;
      end
      StRun: begin
        if (mem_wait) begin
          // The cycle that raised the wait is already the first wait cycle.
          state_d    = StMemWait;
          wait_cnt_d = WcW'(1);
        end
      end
      StMemWait: begin
        if (mem_ack)                  state_d    = StRun;
        else if (wait_cnt_q != WaitMax) wait_cnt_d = wait_cnt_q + 1'b1;
      end
      default: state_d = StReset;
    endcase
    // Sticky; the controller keeps waiting after the timeout is flagged.
    mem_err_d = mem_err_q || ((state_d == StMemWait) && (wait_cnt_d == WaitMax));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReset;
      rst_cnt_q     <= RstLoad;
      wait_cnt_q    <= '0;
      mem_err_q     <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_err_q     <= mem_err_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign if_rst      = ctl.if_rst;
  assign id_rst      = ctl.id_rst;
  assign exe_rst     = ctl.exe_rst;
  assign mem_rst     = ctl.mem_rst;
  assign wb_rst      = ctl.wb_rst;
  assign if_en       = ctl.if_en;
  assign id_en       = ctl.id_en;
  assign exe_en      = ctl.exe_en;
  assign mem_en      = ctl.mem_en;
  assign wb_en       = ctl.wb_en;
  assign mem_err     = mem_err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;

endmodule

// File: tb/tb_stage_ctrl.sv
// Directed bench for stage_ctrl: reset release, RAW stalls, branch flush,
// branch+RAW interaction, memory wait, zero-stall ack, timeout and mid-wait reset.
module tb_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, rs_used_id, rt_used_id;
  logic [2:0]  pc_src_ctrl;
  logic [4:0]  addr_rs_id, addr_rt_id, regw_addr_exe, regw_addr_mem;
  logic        is_branch_exe, is_branch_mem, wb_wen_exe, wb_wen_mem;
  logic        mem_ren, mem_wen, mem_ack;
  logic        if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic        if_en, id_en, exe_en, mem_en, wb_en;
  logic        mem_err;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

  logic [4:0] rsts, ens;
  assign rsts = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};
  assign ens  = {if_en, id_en, exe_en, mem_en, wb_en};

  int checks = 0;
  int errors = 0;

  stage_ctrl #(
    .RST_CYCLES  (4),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .pc_src_ctrl   (pc_src_ctrl),
    .rs_used_id    (rs_used_id),
    .rt_used_id    (rt_used_id),
    .addr_rs_id    (addr_rs_id),
    .addr_rt_id    (addr_rt_id),
    .is_branch_exe (is_branch_exe),
    .is_branch_mem (is_branch_mem),
    .regw_addr_exe (regw_addr_exe),
    .regw_addr_mem (regw_addr_mem),
    .wb_wen_exe    (wb_wen_exe),
    .wb_wen_mem    (wb_wen_mem),
    .mem_ren       (mem_ren),
    .mem_wen       (mem_wen),
    .mem_ack       (mem_ack),
    .if_rst        (if_rst),
    .id_rst        (id_rst),
    .exe_rst       (exe_rst),
    .mem_rst       (mem_rst),
    .wb_rst        (wb_rst),
    .if_en         (if_en),
    .id_en         (id_en),
    .exe_en        (exe_en),
    .mem_en        (mem_en),
    .wb_en         (wb_en),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .memwait_cnt   (memwait_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 3 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; pc_src_ctrl = 3'd0; rs_used_id = 1'b0; rt_used_id = 1'b0;
    addr_rs_id = 5'd0; addr_rt_id = 5'd0; is_branch_exe = 1'b0; is_branch_mem = 1'b0;
    regw_addr_exe = 5'd0; regw_addr_mem = 5'd0; wb_wen_exe = 1'b0; wb_wen_mem = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      checks++;
      if (rsts !== 5'b11111 || ens !== 5'b00000) begin
        errors++;
        $display("FAIL reset_held[%0d]: rst=%b en=%b expected rst=11111 en=00000", i, rsts, ens);
      end
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (rsts !== 5'b11111 || ens !== 5'b00000) begin
        errors++;
        $display("FAIL reset_release[%0d]: rst=%b en=%b expected rst=11111 en=00000",
                 i, rsts, ens);
      end
      tick();
    end
    settle();
    checks++;
    if (rsts !== 5'b00000 || ens !== 5'b11111) begin
      errors++;
      $display("FAIL reset_first_run: rst=%b en=%b expected rst=00000 en=11111", rsts, ens);
    end
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || memwait_cnt !== 0 || mem_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: stall=%0d flush=%0d memwait=%0d err=%b expected 0 0 0 0",
               stall_cnt, flush_cnt, memwait_cnt, mem_err);
    end
    tick();
  endtask

  task automatic test_raw_exe();
    idle_inputs();
    id_valid = 1'b1; rs_used_id = 1'b1; addr_rs_id = 5'd5;
    regw_addr_exe = 5'd5; wb_wen_exe = 1'b1;
    settle();
    checks++;
    if (rsts !== 5'b00100 || ens !== 5'b00111) begin
      errors++;
      $display("FAIL raw_exe: rst=%b en=%b expected rst=00100 en=00111", rsts, ens);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++;
      $display("FAIL raw_exe_cnt: got %0d expected 1", stall_cnt);
    end
    // Producer has moved on to MEM.
    wb_wen_exe = 1'b0; regw_addr_mem = 5'd5; wb_wen_mem = 1'b1;
    settle();
    checks++;
    if (rsts !== 5'b00100 || ens !== 5'b00111) begin
      errors++;
      $display("FAIL raw_mem: rst=%b en=%b expected rst=00100 en=00111", rsts, ens);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL raw_mem_cnt: got %0d expected 2", stall_cnt);
    end
    // Register 0 never stalls.
    idle_inputs();
    id_valid = 1'b1; rs_used_id = 1'b1; addr_rs_id = 5'd0;
    regw_addr_exe = 5'd0; wb_wen_exe = 1'b1;
    settle();
    checks++;
    if (rsts !== 5'b00000 || ens !== 5'b11111) begin
      errors++;
      $display("FAIL raw_r0: rst=%b en=%b expected rst=00000 en=11111", rsts, ens);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL raw_r0_cnt: got %0d expected 2", stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    logic [4:0] exp_ens [3];
    exp_ens[0] = 5'b01111; exp_ens[1] = 5'b01111; exp_ens[2] = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      if (i == 0) begin id_valid = 1'b1; pc_src_ctrl = 3'd2; end
      if (i == 1) is_branch_exe = 1'b1;
      if (i == 2) is_branch_mem = 1'b1;
      settle();
      checks++;
      if (rsts !== 5'b01000 || ens !== exp_ens[i]) begin
        errors++;
        $display("FAIL branch[%0d]: rst=%b en=%b expected rst=01000 en=%b",
                 i, rsts, ens, exp_ens[i]);
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (flush_cnt !== 32'd3) begin
      errors++;
      $display("FAIL branch_cnt: got %0d expected 3", flush_cnt);
    end
  endtask

  task automatic test_branch_raw();
    idle_inputs();
    id_valid = 1'b1; pc_src_ctrl = 3'd1; rt_used_id = 1'b1; addr_rt_id = 5'd8;
    regw_addr_mem = 5'd8; wb_wen_mem = 1'b1;
    settle();
    checks++;
    if (rsts !== 5'b00100 || ens !== 5'b00111) begin
      errors++;
      $display("FAIL branch_raw_stall: rst=%b en=%b expected rst=00100 en=00111", rsts, ens);
    end
    tick();
    // Dependency resolved; the held branch now flushes.
    wb_wen_mem = 1'b0;
    settle();
    checks++;
    if (rsts !== 5'b01000 || ens !== 5'b01111) begin
      errors++;
      $display("FAIL branch_raw_flush: rst=%b en=%b expected rst=01000 en=01111", rsts, ens);
    end
    tick();
    checks++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd4) begin
      errors++;
      $display("FAIL branch_raw_cnt: stall=%0d flush=%0d expected 3 4", stall_cnt, flush_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_memwait();
    idle_inputs();
    mem_ren = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (rsts !== 5'b00001 || ens !== 5'b00000) begin
        errors++;
        $display("FAIL memwait[%0d]: rst=%b en=%b expected rst=00001 en=00000", i, rsts, ens);
      end
      tick();
    end
    mem_ack = 1'b1;
    settle();
    checks++;
    if (rsts !== 5'b00000 || ens !== 5'b11111) begin
      errors++;
      $display("FAIL memwait_ack: rst=%b en=%b expected rst=00000 en=11111", rsts, ens);
    end
    tick();
    checks++;
    if (memwait_cnt !== 32'd3) begin
      errors++;
      $display("FAIL memwait_cnt: got %0d expected 3", memwait_cnt);
    end
    // Request acked in its own cycle: no stall at all.
    mem_ren = 1'b0; mem_wen = 1'b1; mem_ack = 1'b1;
    settle();
    checks++;
    if (ens !== 5'b11111 || rsts !== 5'b00000) begin
      errors++;
      $display("FAIL mem_zero_stall: rst=%b en=%b expected rst=00000 en=11111", rsts, ens);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (memwait_cnt !== 32'd3 || ens !== 5'b11111) begin
      errors++;
      $display("FAIL mem_zero_stall_cnt: cnt=%0d en=%b expected 3 11111", memwait_cnt, ens);
    end
    tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    mem_ren = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      settle();
      checks++;
      if (mem_err !== (k >= 5)) begin
        errors++;
        $display("FAIL timeout_err[cycle %0d]: got %b expected %b", k, mem_err, (k >= 5));
      end
      tick();
    end
    mem_ack = 1'b1;
    settle();
    checks++;
    if (mem_err !== 1'b1 || ens !== 5'b11111) begin
      errors++;
      $display("FAIL timeout_ack: err=%b en=%b expected 1 11111", mem_err, ens);
    end
    tick();
    idle_inputs();
    tick(); settle();
    checks++;
    if (mem_err !== 1'b1 || memwait_cnt !== 32'd13) begin
      errors++;
      $display("FAIL timeout_sticky: err=%b memwait=%0d expected 1 13", mem_err, memwait_cnt);
    end
    tick();
  endtask

  task automatic test_reset_midwait();
    idle_inputs();
    mem_wen = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    settle();
    checks++;
    if (mem_err !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0 || memwait_cnt !== 0) begin
      errors++;
      $display("FAIL midwait_rst_clear: err=%b stall=%0d flush=%0d memwait=%0d expected 0",
               mem_err, stall_cnt, flush_cnt, memwait_cnt);
    end
    checks++;
    if (rsts !== 5'b11111 || ens !== 5'b00000) begin
      errors++;
      $display("FAIL midwait_rst_state: rst=%b en=%b expected rst=11111 en=00000", rsts, ens);
    end
    for (int i = 0; i < 4; i++) tick();
    settle();
    checks++;
    if (ens !== 5'b11111 || rsts !== 5'b00000) begin
      errors++;
      $display("FAIL midwait_rerun: rst=%b en=%b expected rst=00000 en=11111", rsts, ens);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_raw_exe();
    test_branch();
    test_branch_raw();
    test_memwait();
    test_timeout();
    test_reset_midwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
